// File: rtl/fire7_pkg.sv
// fire7_pkg
// Shared constants and types for the fire7 expand-1x1 output feature-map
// writer.
//   WOUT     : output map side (WOUT*WOUT pixels per layer)
//   DSP_NO   : channels per pixel vector
//   WR_PORTS : RAM banks written in parallel each cycle
//   GROUPS   : channel groups per pixel (DSP_NO / WR_PORTS)
//   ADDR_W   : bank address width, wide enough for GROUPS*WOUT*WOUT words
//   wr_state_t : writer FSM state
package fire7_pkg;

  localparam int WOUT     = 16;
  localparam int DSP_NO   = 192;
  localparam int WR_PORTS = 4;
  localparam int GROUPS   = DSP_NO / WR_PORTS;
  localparam int ADDR_W   = $clog2(GROUPS * WOUT * WOUT);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } wr_state_t;

endpackage

// File: rtl/fire7_expand1_ofm_writer_ofm_group_mux.sv
// ofm_group_mux
// Combinational selector that picks one group of WR_PORTS consecutive
// channels out of the captured pixel vector.
// Ports:
//   shadow : captured channel vector, DSP_NO words of WIDTH bits
//   grp    : group index; word b of the result is channel grp*WR_PORTS+b
//   words  : WR_PORTS selected words, one per RAM bank
module ofm_group_mux #(
  parameter int WIDTH    = 16,
  parameter int DSP_NO   = 192,
  parameter int WR_PORTS = 4,
  parameter int GRP_W    = 6
) (
  input  logic [WIDTH-1:0] shadow [0:DSP_NO-1],
  input  logic [GRP_W-1:0] grp,
  output logic [WIDTH-1:0] words  [0:WR_PORTS-1]
);

  localparam int IDX_W = $clog2(DSP_NO);

  // Bank b always receives the channel at offset b within the group, so the
  // RAM ends up channel-major with WR_PORTS channels interleaved per address.
  always_comb begin
    for (int b = 0; b < WR_PORTS; b++) begin
      words[b] = shadow[IDX_W'(int'(grp) * WR_PORTS + b)];
    end
  end

endmodule

// File: rtl/fire7_expand1_ofm_writer.sv
// fire7_expand1_ofm_writer
// Captures the expand-1x1 output vector on each sample strobe and drains it
// group by group into a WR_PORTS-bank feature-map RAM. After the last pixel
// of the map has been written, a one-cycle ram_feedback pulse is sent back
// to the layer and layer_done stays high until reset.
// Ports:
//   clk                  : clock
//   rst                  : asynchronous reset, active low
//   fire7_expand1_sample : one-cycle strobe, ofm valid in the same cycle
//   ofm                  : DSP_NO post-ReLU channel words
//   wr_en                : write strobe shared by all banks
//   wr_addr              : shared bank address (grp*WOUT*WOUT + pix)
//   wr_data              : one word per bank, bank b gets channel grp*WR_PORTS+b
//   ram_feedback         : one-cycle pulse after the final write of the map
//   layer_done           : level, high once every pixel has been stored
//   overrun_err          : sticky, set when a sample had to be dropped
module fire7_expand1_ofm_writer #(
  parameter int WIDTH    = 16,
  parameter int DSP_NO   = fire7_pkg::DSP_NO,
  parameter int WOUT     = fire7_pkg::WOUT,
  parameter int WR_PORTS = fire7_pkg::WR_PORTS,
  parameter int ADDR_W   = $clog2(DSP_NO / WR_PORTS * WOUT * WOUT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire7_expand1_sample,
  input  logic [WIDTH-1:0]  ofm     [0:DSP_NO-1],
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data [0:WR_PORTS-1],
  output logic              ram_feedback,
  output logic              layer_done,
  output logic              overrun_err
);

  import fire7_pkg::*;

  localparam int NGROUPS = DSP_NO / WR_PORTS;
  localparam int NPIX    = WOUT * WOUT;
  localparam int GRP_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam int PIX_W   = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [GRP_W-1:0]  LAST_GRP = GRP_W'(NGROUPS - 1);
  localparam logic [PIX_W-1:0]  LAST_PIX = PIX_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] PIX_STRIDE = ADDR_W'(NPIX);

  wr_state_t         state, state_n;
  logic [GRP_W-1:0]  grp, grp_n;
  logic [PIX_W-1:0]  pix, pix_n;
  logic              capture;
  logic              do_write;
  logic              overrun_set;

  logic [WIDTH-1:0]  shadow    [0:DSP_NO-1];
  logic [WIDTH-1:0]  grp_words [0:WR_PORTS-1];
  logic [ADDR_W-1:0] addr_c;

  ofm_group_mux #(
    .WIDTH    (WIDTH),
    .DSP_NO   (DSP_NO),
    .WR_PORTS (WR_PORTS),
    .GRP_W    (GRP_W)
  ) u_group_mux (
    .shadow (shadow),
    .grp    (grp),
    .words  (grp_words)
  );

  // Channel-major layout: all pixels of group 0 first, then group 1, ...
  assign addr_c = ADDR_W'(grp) * PIX_STRIDE + ADDR_W'(pix);

  // FSM state and drain counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grp   <= '0;
      pix   <= '0;
    end else begin
      state <= state_n;
      grp   <= grp_n;
      pix   <= pix_n;
    end
  end

  // Next-state logic. A sample is only taken in IDLE, or on the last group
  // of a drain when more pixels remain, which lets the upstream run with a
  // period as short as one drain. Any other sample is dropped and flagged.
  always_comb begin
    state_n     = state;
    grp_n       = grp;
    pix_n       = pix;
    capture     = 1'b0;
    do_write    = 1'b0;
    overrun_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (fire7_expand1_sample) begin
          capture = 1'b1;
          grp_n   = '0;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        do_write = 1'b1;
        if (grp == LAST_GRP) begin
          grp_n = '0;
          if (pix == LAST_PIX) begin
            state_n     = DONE;
            overrun_set = fire7_expand1_sample;
          end else begin
            pix_n = pix + PIX_W'(1);
            if (fire7_expand1_sample) begin
              capture = 1'b1;
              state_n = DRAIN;
            end else begin
              state_n = IDLE;
            end
          end
        end else begin
          grp_n       = grp + GRP_W'(1);
          overrun_set = fire7_expand1_sample;
        end
      end
      DONE: begin
        overrun_set = fire7_expand1_sample;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // The shadow copy needs no reset: it is always written before it is read.
  always_ff @(posedge clk) begin
    if (capture) begin
      shadow <= ofm;
    end
  end

  // Registered RAM write port and status flags. ram_feedback fires on the
  // first cycle spent in DONE, which is also when layer_done rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      for (int b = 0; b < WR_PORTS; b++) begin
        wr_data[b] <= '0;
      end
      ram_feedback <= 1'b0;
      layer_done   <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      wr_en <= do_write;
      if (do_write) begin
        wr_addr <= addr_c;
        wr_data <= grp_words;
      end
      ram_feedback <= (state == DONE) && !layer_done;
      layer_done   <= layer_done || (state == DONE);
      overrun_err  <= overrun_err || overrun_set;
    end
  end

endmodule

// File: tb/tb_fire7_expand1_ofm_writer.sv
// tb_fire7_expand1_ofm_writer
// Self-checking bench for fire7_expand1_ofm_writer. A behavioural model
// decides, edge by edge, whether each sample is taken or dropped and builds
// a per-cycle schedule of the expected RAM writes, feedback and status
// flags. Every cycle the outputs are compared against that schedule, and a
// few literal expectations pin down the model itself.
module tb_fire7_expand1_ofm_writer;

  localparam int WIDTH    = 16;
  localparam int DSP_NO   = 192;
  localparam int WOUT     = 16;
  localparam int WR_PORTS = 4;
  localparam int ADDR_W   = 14;
  localparam int NPIX     = WOUT * WOUT;
  localparam int NGRP     = DSP_NO / WR_PORTS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              sample = 1'b0;
  logic [WIDTH-1:0]  ofm     [0:DSP_NO-1];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data [0:WR_PORTS-1];
  logic              ram_feedback;
  logic              layer_done;
  logic              overrun_err;

  always #5 clk = ~clk;

  fire7_expand1_ofm_writer #(
    .WIDTH    (WIDTH),
    .DSP_NO   (DSP_NO),
    .WOUT     (WOUT),
    .WR_PORTS (WR_PORTS),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .fire7_expand1_sample (sample),
    .ofm                  (ofm),
    .wr_en                (wr_en),
    .wr_addr              (wr_addr),
    .wr_data              (wr_data),
    .ram_feedback         (ram_feedback),
    .layer_done           (layer_done),
    .overrun_err          (overrun_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected schedule, keyed by the number of the rising edge after which
  // the value must be visible.
  bit          expWr   [int];
  int          expAddr [int];
  logic [63:0] expData [int];

  int curStart = -1000;
  int curPix   = 0;
  int pixCount = 0;
  int fbEdge   = -1;
  int ovrEdge  = -1;
  bit doneM    = 1'b0;
  int fbPulses = 0;
  bit randomData = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [63:0] packedData();
    logic [63:0] d;
    d = '0;
    for (int b = 0; b < WR_PORTS; b++) d[b*16 +: 16] = wr_data[b];
    return d;
  endfunction

  task automatic clearModel();
    expWr.delete();
    expAddr.delete();
    expData.delete();
    curStart = -1000;
    curPix   = 0;
    pixCount = 0;
    fbEdge   = -1;
    ovrEdge  = -1;
    doneM    = 1'b0;
  endtask

  // Decide what a sample seen at edge cyc does: a sample is taken when the
  // writer is free, or on the final write of a drain if the map is not yet
  // complete; everything else is dropped and raises the error flag.
  task automatic modelEdge(input bit doSample);
    bit busy;
    bit lastGrp;
    logic [63:0] d;
    if (!doSample) return;
    busy    = (cyc > curStart) && (cyc <= curStart + NGRP);
    lastGrp = (cyc == curStart + NGRP);
    if (!doneM && (!busy || (lastGrp && curPix != NPIX - 1))) begin
      curStart = cyc;
      curPix   = pixCount;
      pixCount++;
      for (int g = 0; g < NGRP; g++) begin
        d = '0;
        for (int b = 0; b < WR_PORTS; b++) d[b*16 +: 16] = ofm[g*WR_PORTS + b];
        expWr[cyc + 1 + g]   = 1'b1;
        expAddr[cyc + 1 + g] = g * NPIX + curPix;
        expData[cyc + 1 + g] = d;
      end
      if (curPix == NPIX - 1) begin
        doneM  = 1'b1;
        fbEdge = cyc + NGRP + 1;
      end
    end else if (ovrEdge < 0) begin
      ovrEdge = cyc;
    end
  endtask

  task automatic checkOutput();
    check("wr_en", wr_en, expWr.exists(cyc));
    if (expWr.exists(cyc)) begin
      check("wr_addr", wr_addr, expAddr[cyc]);
      check("wr_data", packedData(), expData[cyc]);
    end
    check("ram_feedback", ram_feedback, cyc == fbEdge);
    check("layer_done", layer_done, (fbEdge >= 0) && (cyc >= fbEdge));
    check("overrun_err", overrun_err, (ovrEdge >= 0) && (cyc >= ovrEdge));
    if (ram_feedback) fbPulses++;
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model,
  // then compare on the falling edge.
  task automatic applyStimulus(input bit doSample);
    for (int c = 0; c < DSP_NO; c++) begin
      ofm[c] = randomData ? WIDTH'($urandom_range(0, 65535)) : WIDTH'(c);
    end
    sample = doSample;
    @(posedge clk);
    cyc++;
    modelEdge(doSample);
    @(negedge clk);
    sample = 1'b0;
    checkOutput();
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, packedData(), 0);
    check({tag, "_ram_feedback"}, ram_feedback, 0);
    check({tag, "_layer_done"}, layer_done, 0);
    check({tag, "_overrun_err"}, overrun_err, 0);
  endtask

  initial begin
    int gap;
    for (int c = 0; c < DSP_NO; c++) ofm[c] = '0;

    // Power-on reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b1;

    // Pixel 0 with ofm[c] = c: 48 writes, known first and last words.
    randomData = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    check("first_addr", wr_addr, 0);
    check("first_data", packedData(), {16'd3, 16'd2, 16'd1, 16'd0});
    repeat (46) applyStimulus(1'b0);
    applyStimulus(1'b0);
    check("last_addr", wr_addr, 12032);
    check("last_data", packedData(), {16'd191, 16'd190, 16'd189, 16'd188});
    applyStimulus(1'b0);
    check("idle_after_drain", wr_en, 0);
    repeat (15) applyStimulus(1'b0);

    // Pixel 1, then pixel 2 offered on its last group (back-to-back).
    randomData = 1'b1;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    check("pix1_first_addr", wr_addr, 1);
    repeat (46) applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    check("b2b_wr_en", wr_en, 1);
    check("b2b_addr", wr_addr, 2);
    check("b2b_overrun", overrun_err, 0);
    repeat (47 + 16) applyStimulus(1'b0);

    // Pixel 3 with a stray sample while group 10 is being drained.
    applyStimulus(1'b1);
    repeat (10) applyStimulus(1'b0);
    applyStimulus(1'b1);
    check("stray_overrun", overrun_err, 1);
    repeat (37 + 16) applyStimulus(1'b0);

    // Pixel 4 normally, pixel 5 interrupted by reset around group 20.
    applyStimulus(1'b1);
    repeat (64) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (20) applyStimulus(1'b0);
    rst = 1'b0;
    #1;
    clearModel();
    checkAllZero("midreset");
    @(posedge clk);
    cyc++;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;

    // A complete map from scratch, mostly at the 65-cycle upstream period
    // with occasional back-to-back samples.
    for (int k = 0; k < NPIX; k++) begin
      gap = ($urandom_range(0, 7) == 0) ? NGRP : 65;
      applyStimulus(1'b1);
      if (k == NPIX - 1) begin
        for (int t = 1; t <= 60; t++) begin
          applyStimulus(1'b0);
          if (t == NGRP) check("final_addr", wr_addr, 12287);
          if (t == NGRP + 1) begin
            check("final_feedback", ram_feedback, 1);
            check("final_layer_done", layer_done, 1);
          end
        end
      end else begin
        for (int t = 1; t < gap; t++) begin
          applyStimulus(1'b0);
          if (k == 0 && t == 1) begin
            check("fresh_wr_en", wr_en, 1);
            check("fresh_addr", wr_addr, 0);
          end
        end
      end
    end
    check("feedback_pulses", fbPulses, 1);

    // Samples after the map is complete are refused.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1);
      repeat ($urandom_range(3, 20)) applyStimulus(1'b0);
    end
    check("done_overrun", overrun_err, 1);
    check("done_level", layer_done, 1);
    check("done_no_write", wr_en, 0);
    check("feedback_once", fbPulses, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fire7_expand1_ofm_writer.md
# fire7_expand1_ofm_writer

Downstream stage of the fire7 expand-1x1 layer.
- Captures the 192-channel output vector on each sample strobe and drains it into a 4-bank feature-map RAM in channel-major order.
- Returns `ram_feedback` to the layer once all WOUT² pixels are stored.
- Sits between the expand MAC array and the RAM read by the fire7 concat / fire8 squeeze stage.

## Interface
Parameters:
- `WIDTH`, 16: output word width.
- `DSP_NO`, 192: channels per pixel vector.
- `WOUT`, 16: output map side; WOUT² = 256 pixels.
- `WR_PORTS`, 4: RAM banks written per cycle; DSP_NO must be a multiple of it.
- `ADDR_W`, $clog2(DSP_NO/WR_PORTS*WOUT**2) = 14: bank address width.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `fire7_expand1_sample` in 1: one-cycle strobe; `ofm` is valid in the same cycle.
- `ofm` in WIDTH × [0:DSP_NO-1]: post-ReLU channel vector.
- `wr_en` out 1: write strobe, common to all banks.
- `wr_addr` out ADDR_W: shared bank address.
- `wr_data` out WIDTH × [0:WR_PORTS-1]: bank b receives channel g·WR_PORTS+b.
- `ram_feedback` out 1: one-cycle pulse after the final write.
- `layer_done` out 1: level, high once all pixels are stored.
- `overrun_err` out 1: sticky, set when a sample is dropped.

## Operation
- FSM states: IDLE, DRAIN, DONE.
- Counters:
  - pixel counter `pix` 0..WOUT²-1.
  - group counter `grp` 0..DSP_NO/WR_PORTS-1 (0..47).
- IDLE + sample:
  - Register `ofm` into the shadow array.
  - Set grp ← 0 and go to DRAIN.
- DRAIN, each cycle:
  - wr_en = 1.
  - wr_data[b] = shadow[grp·WR_PORTS+b].
  - wr_addr = grp·WOUT² + pix.
  - grp increments.
- DRAIN on the last group (grp = 47):
  - If pix = WOUT²-1: go to DONE and pulse `ram_feedback`.
  - Otherwise: pix increments and the FSM returns to IDLE.
- Sample accepted while in DRAIN on the last group with pix ≠ WOUT²-1:
  - The shadow is recaptured and grp ← 0; the FSM stays in DRAIN (back-to-back).
- Any other sample while in DRAIN, or any sample while in DONE:
  - The sample is ignored and `overrun_err` is set.
- DONE:
  - `layer_done` = 1.
  - No writes occur.
  - The FSM leaves DONE only on reset.
- Address arithmetic is unsigned and zero-extended to ADDR_W. No wrap is possible: the maximum address is 47·256+255 = 12287 < 2^14.

## Timing
- Reset values:
  - State IDLE; pix, grp = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - ram_feedback = 0, layer_done = 0, overrun_err = 0.
  - The shadow array is not reset.
- Outputs are registered. For a sample at edge T:
  - First write (grp 0) is presented in cycle T+1.
  - Write for group g is in cycle T+1+g; the last is at T+48.
  - Drain length is 48 cycles.
- The upstream sample period is CHIN+1 = 65 cycles, so there is 17 cycles of margin. Back-to-back acceptance allows a period as short as 48.
- `ram_feedback` is high in the cycle after the final write (T+49) for exactly one cycle.
- `layer_done` rises in the same cycle as `ram_feedback`.
- Reset asserted mid-drain: all outputs clear immediately (asynchronous). Writes in flight are abandoned and no feedback is generated.

## Structure
- Package `fire7_pkg` holds:
  - Constants WOUT, DSP_NO, WR_PORTS, ADDR_W, and GROUPS = DSP_NO/WR_PORTS.
  - The FSM state enum `wr_state_t`.
- One natural sub-module: `ofm_group_mux`, a combinational selector of WR_PORTS words from the shadow array by `grp`.

## Test plan
- Reset then one sample with ofm[c] = c:
  - 48 writes at T+1..T+48.
  - First write: wr_addr 0, data {0,1,2,3}.
  - Last write: wr_addr 47·256 = 12032, data {188..191}.
  - Returns to IDLE with pix = 1.
- 256 samples at a 65-cycle period:
  - A bank model checks every word.
  - The last write is at address 12287.
  - `ram_feedback` pulses once; `layer_done` stays high.
- Back-to-back: second sample in the cycle of grp = 47:
  - Accepted, and grp 0 of pixel 1 is written in the next cycle.
  - `overrun_err` stays 0.
- Sample at grp = 10 during DRAIN:
  - Ignored, and `overrun_err` rises.
  - The current pixel completes with the original data.
- Samples after DONE:
  - No wr_en and `overrun_err` = 1.
  - `ram_feedback` does not re-pulse.
- rst low at grp = 20 of pixel 5:
  - wr_en drops immediately and all outputs are 0.
  - A fresh sample then writes pixel 0 at address 0.
